// File: rtl/seg_scan_capture.sv
// seg_scan_capture: recovers four digit patterns from a scanned, active-low 7-segment bus.
// Optional macro SEG_SCAN_SYNC_EN inserts a 2-flop input synchronizer ahead of the filter.
module seg_scan_capture #(
    parameter int NB_DISPLAYS   = 4,
    parameter int STABLE_CYCLES = 16,
    parameter int TIMEOUT_BITS  = 20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_seg,
    input  logic [3:0] i_an,
    output logic [6:0] o_digit0,
    output logic [6:0] o_digit1,
    output logic [6:0] o_digit2,
    output logic [6:0] o_digit3,
    output logic [3:0] o_hex0,
    output logic [3:0] o_hex1,
    output logic [3:0] o_hex2,
    output logic [3:0] o_hex3,
    output logic [3:0] o_hex_ok,
    output logic [3:0] o_valid,
    output logic       o_frame_done,
    output logic       o_stall
);
    localparam logic [10:0] IDLE       = {4'hF, 7'h7F};
    localparam logic [7:0]  STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0]  CAP_AT     = 8'(STABLE_CYCLES - 2);

    logic [10:0]             samp;
    logic [10:0]             prev_q;
    logic [7:0]              dwell_q, dwell_d;
    logic [6:0]              digit_q [NB_DISPLAYS];
    logic [6:0]              digit_d [NB_DISPLAYS];
    logic [4:0]              dec     [NB_DISPLAYS];
    logic [3:0]              valid_q, valid_d;
    logic [3:0]              seen_q, seen_d;
    logic                    frame_q, frame_d;
    logic [TIMEOUT_BITS-1:0] stall_q, stall_d;
    logic                    same, an_ok, capture;
    logic [1:0]              an_idx;
    logic [3:0]              cap_bit;

`ifdef SEG_SCAN_SYNC_EN
    logic [10:0] sync1_q, sync2_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q <= IDLE;
            sync2_q <= IDLE;
        end else begin
            sync1_q <= {i_an, i_seg};
            sync2_q <= sync1_q;
        end
    end

    assign samp = sync2_q;
`else
    assign samp = {i_an, i_seg};
`endif

    // Only a single driven (low) anode identifies a digit.
    always_comb begin
        an_ok  = 1'b1;
        an_idx = 2'd0;
        case (samp[10:7])
            4'b1110: an_idx = 2'd0;
            4'b1101: an_idx = 2'd1;
            4'b1011: an_idx = 2'd2;
            4'b0111: an_idx = 2'd3;
            default: an_ok  = 1'b0;
        endcase
    end

    always_comb begin
        same    = (samp == prev_q);
        // Counter reaching STABLE_CYCLES-1 marks the STABLE_CYCLES-th identical sample.
        capture = same && an_ok && (dwell_q == CAP_AT);
        cap_bit = 4'b0001 << an_idx;

        if (!same)
            dwell_d = '0;
        else if (dwell_q != STABLE_MAX)
            dwell_d = dwell_q + 8'd1;
        else
            dwell_d = dwell_q;

        digit_d = digit_q;
        valid_d = valid_q;
        seen_d  = seen_q;
        frame_d = 1'b0;
        stall_d = (&stall_q) ? stall_q : stall_q + TIMEOUT_BITS'(1);

        if (capture) begin
            digit_d[an_idx] = samp[6:0];
            valid_d         = valid_q | cap_bit;
            stall_d         = '0;
            if ((seen_q | cap_bit) == 4'hF) begin
                seen_d  = '0;
                frame_d = 1'b1;
            end else begin
                seen_d  = seen_q | cap_bit;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prev_q  <= IDLE;
            dwell_q <= '0;
            for (int n = 0; n < NB_DISPLAYS; n++) digit_q[n] <= 7'h7F;
            valid_q <= '0;
            seen_q  <= '0;
            frame_q <= 1'b0;
            stall_q <= '0;
        end else begin
            prev_q  <= samp;
            dwell_q <= dwell_d;
            digit_q <= digit_d;
            valid_q <= valid_d;
            seen_q  <= seen_d;
            frame_q <= frame_d;
            stall_q <= stall_d;
        end
    end

    // Returns {match, hex}; patterns are active-low {g..a}.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h40:   decode = {1'b1, 4'h0};
            7'h79:   decode = {1'b1, 4'h1};
            7'h24:   decode = {1'b1, 4'h2};
            7'h30:   decode = {1'b1, 4'h3};
            7'h19:   decode = {1'b1, 4'h4};
            7'h12:   decode = {1'b1, 4'h5};
            7'h02:   decode = {1'b1, 4'h6};
            7'h78:   decode = {1'b1, 4'h7};
            7'h00:   decode = {1'b1, 4'h8};
            7'h10:   decode = {1'b1, 4'h9};
            7'h08:   decode = {1'b1, 4'hA};
            7'h03:   decode = {1'b1, 4'hB};
            7'h46:   decode = {1'b1, 4'hC};
            7'h21:   decode = {1'b1, 4'hD};
            7'h06:   decode = {1'b1, 4'hE};
            7'h0E:   decode = {1'b1, 4'hF};
            default: decode = 5'd0;
        endcase
    endfunction

    always_comb begin
        for (int n = 0; n < NB_DISPLAYS; n++) dec[n] = decode(digit_q[n]);
    end

    assign o_digit0     = digit_q[0];
    assign o_digit1     = digit_q[1];
    assign o_digit2     = digit_q[2];
    assign o_digit3     = digit_q[3];
    assign o_hex0       = dec[0][3:0];
    assign o_hex1       = dec[1][3:0];
    assign o_hex2       = dec[2][3:0];
    assign o_hex3       = dec[3][3:0];
    assign o_hex_ok     = {dec[3][4], dec[2][4], dec[1][4], dec[0][4]};
    assign o_valid      = valid_q;
    assign o_frame_done = frame_q;
    assign o_stall      = &stall_q;
endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: directed scenarios plus randomized scan traffic
// checked against a run-length reference model of the capture rules.
module tb_seg_scan_capture;
    localparam int S        = 4;
    localparam int TB       = 6;
    localparam int MAX_IDLE = (1 << TB) - 1;
`ifdef SEG_SCAN_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic [6:0] i_seg = 7'h7F;
    logic [3:0] i_an  = 4'hF;
    logic [6:0] o_digit0, o_digit1, o_digit2, o_digit3;
    logic [3:0] o_hex0, o_hex1, o_hex2, o_hex3;
    logic [3:0] o_hex_ok, o_valid;
    logic       o_frame_done, o_stall;

    int tests_run    = 0;
    int tests_failed = 0;
    int frame_cnt    = 0;
    logic saw_40     = 1'b0;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    logic [6:0]  m_digit [4];
    logic [3:0]  m_valid, m_seen;
    logic        m_frame;
    int          m_idle, m_run;
    logic [10:0] m_last;
    logic [10:0] pipe [$];

    seg_scan_capture #(
        .NB_DISPLAYS  (4),
        .STABLE_CYCLES(S),
        .TIMEOUT_BITS (TB)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_seg       (i_seg),
        .i_an        (i_an),
        .o_digit0    (o_digit0),
        .o_digit1    (o_digit1),
        .o_digit2    (o_digit2),
        .o_digit3    (o_digit3),
        .o_hex0      (o_hex0),
        .o_hex1      (o_hex1),
        .o_hex2      (o_hex2),
        .o_hex3      (o_hex3),
        .o_hex_ok    (o_hex_ok),
        .o_valid     (o_valid),
        .o_frame_done(o_frame_done),
        .o_stall     (o_stall)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        logic [4:0] r;
        r = 5'd0;
        for (int h = 0; h < 16; h++) if (glyph[h] == p) r = {1'b1, 4'(h)};
        return r;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 4; n++) m_digit[n] = 7'h7F;
        m_valid = 4'h0;
        m_seen  = 4'h0;
        m_frame = 1'b0;
        m_idle  = 0;
        m_run   = 0;
        m_last  = 11'h7FF;
        pipe.delete();
        for (int i = 0; i < LAT; i++) pipe.push_back(11'h7FF);
    endtask

    // A value is accepted when it is the S-th identical consecutive sample.
    task automatic model_edge(input logic [10:0] x);
        logic [10:0] v;
        int zeros, idx;
        pipe.push_back(x);
        v = pipe.pop_front();
        if (v == m_last) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run = 1;
        end
        m_last = v;
        zeros = 0;
        idx   = 0;
        for (int b = 0; b < 4; b++) if (!v[7+b]) begin zeros++; idx = b; end
        m_frame = 1'b0;
        if (m_run == S && zeros == 1) begin
            m_digit[idx] = v[6:0];
            m_valid[idx] = 1'b1;
            m_seen[idx]  = 1'b1;
            if (m_seen == 4'hF) begin
                m_frame = 1'b1;
                m_seen  = 4'h0;
            end
            m_idle = 0;
        end else if (m_idle < MAX_IDLE) begin
            m_idle++;
        end
    endtask

    function automatic logic [53:0] exp_vec();
        logic [4:0] d0, d1, d2, d3;
        d0 = ref_decode(m_digit[0]);
        d1 = ref_decode(m_digit[1]);
        d2 = ref_decode(m_digit[2]);
        d3 = ref_decode(m_digit[3]);
        return {m_digit[3], m_digit[2], m_digit[1], m_digit[0],
                d3[3:0], d2[3:0], d1[3:0], d0[3:0], {d3[4], d2[4], d1[4], d0[4]},
                m_valid, m_frame, (m_idle == MAX_IDLE)};
    endfunction

    logic [53:0] dut_vec;
    assign dut_vec = {o_digit3, o_digit2, o_digit1, o_digit0, o_hex3, o_hex2, o_hex1, o_hex0,
                      o_hex_ok, o_valid, o_frame_done, o_stall};

    task automatic mon_update();
        if (o_frame_done === 1'b1) frame_cnt++;
        if (o_digit0 === 7'h40) saw_40 = 1'b1;
    endtask

    // Inputs change on the falling edge; outputs are looked at 1 ns after the rising edge.
    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge i_clk);
            i_an  = an;
            i_seg = seg;
            @(posedge i_clk);
            model_edge({an, seg});
            #1;
            mon_update();
        end
    endtask

    task automatic do_reset(input logic [3:0] an, input logic [6:0] seg);
        @(negedge i_clk);
        i_rst = 1'b1;
        i_an  = an;
        i_seg = seg;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        i_rst = 1'b1;
        model_reset();
        #1;
        tests_run++; if (o_digit0 !== 7'h7F) begin tests_failed++; $display("FAIL reset_digit0 got %h exp 7f", o_digit0); end
        tests_run++; if (o_digit1 !== 7'h7F) begin tests_failed++; $display("FAIL reset_digit1 got %h exp 7f", o_digit1); end
        tests_run++; if (o_digit2 !== 7'h7F) begin tests_failed++; $display("FAIL reset_digit2 got %h exp 7f", o_digit2); end
        tests_run++; if (o_digit3 !== 7'h7F) begin tests_failed++; $display("FAIL reset_digit3 got %h exp 7f", o_digit3); end
        tests_run++; if (o_valid !== 4'h0) begin tests_failed++; $display("FAIL reset_valid got %h exp 0", o_valid); end
        tests_run++; if (o_frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_frame got %b exp 0", o_frame_done); end
        tests_run++; if (o_hex_ok !== 4'h0) begin tests_failed++; $display("FAIL reset_hex_ok got %h exp 0", o_hex_ok); end
        tests_run++; if (o_stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got %b exp 0", o_stall); end
        tests_run++; if (o_hex0 !== 4'h0) begin tests_failed++; $display("FAIL reset_hex0 got %h exp 0", o_hex0); end
        repeat (2) @(posedge i_clk);
        #1;
        tests_run++; if (o_digit0 !== 7'h7F) begin tests_failed++; $display("FAIL reset_hold_digit0 got %h exp 7f", o_digit0); end
        i_rst = 1'b0;
    endtask

    task automatic test_capture_latency();
        do_reset(4'hF, 7'h7F);
        drive(4'b1110, 7'h79, S + LAT - 1);
        tests_run++; if (o_digit0 !== 7'h7F) begin tests_failed++; $display("FAIL latency_early got %h exp 7f", o_digit0); end
        drive(4'b1110, 7'h79, 1);
        tests_run++; if (o_digit0 !== 7'h79) begin tests_failed++; $display("FAIL latency_digit0 got %h exp 79", o_digit0); end
        tests_run++; if (o_hex0 !== 4'h1) begin tests_failed++; $display("FAIL latency_hex0 got %h exp 1", o_hex0); end
        tests_run++; if (o_hex_ok !== 4'b0001) begin tests_failed++; $display("FAIL latency_hex_ok got %b exp 0001", o_hex_ok); end
        tests_run++; if (o_valid !== 4'b0001) begin tests_failed++; $display("FAIL latency_valid got %b exp 0001", o_valid); end
    endtask

    task automatic test_loopback();
        logic [6:0] pats [4];
        pats = '{7'h79, 7'h24, 7'h30, 7'h19};
        do_reset(4'hF, 7'h7F);
        frame_cnt = 0;
        for (int scan = 0; scan < 3; scan++)
            for (int d = 0; d < 4; d++) drive(4'(~(4'b0001 << d)), pats[d], 12);
        tests_run++; if ({o_hex3, o_hex2, o_hex1, o_hex0} !== 16'h4321) begin tests_failed++; $display("FAIL loop_hex got %h exp 4321", {o_hex3, o_hex2, o_hex1, o_hex0}); end
        tests_run++; if (o_hex_ok !== 4'hF) begin tests_failed++; $display("FAIL loop_hex_ok got %h exp f", o_hex_ok); end
        tests_run++; if (o_valid !== 4'hF) begin tests_failed++; $display("FAIL loop_valid got %h exp f", o_valid); end
        tests_run++; if (frame_cnt !== 3) begin tests_failed++; $display("FAIL loop_frames got %0d exp 3", frame_cnt); end
    endtask

    task automatic test_glitch();
        do_reset(4'hF, 7'h7F);
        saw_40 = 1'b0;
        drive(4'b1110, 7'h40, 3);
        drive(4'b1110, 7'h79, 10);
        tests_run++; if (saw_40 !== 1'b0) begin tests_failed++; $display("FAIL glitch_seen got %b exp 0", saw_40); end
        tests_run++; if (o_digit0 !== 7'h79) begin tests_failed++; $display("FAIL glitch_digit0 got %h exp 79", o_digit0); end
        tests_run++; if (o_hex0 !== 4'h1) begin tests_failed++; $display("FAIL glitch_hex0 got %h exp 1", o_hex0); end
    endtask

    task automatic test_invalid_anode();
        do_reset(4'hF, 7'h7F);
        frame_cnt = 0;
        drive(4'hF, 7'h24, 100);
        drive(4'b1100, 7'h24, 100);
        tests_run++; if (o_valid !== 4'h0) begin tests_failed++; $display("FAIL inval_valid got %h exp 0", o_valid); end
        tests_run++; if (frame_cnt !== 0) begin tests_failed++; $display("FAIL inval_frames got %0d exp 0", frame_cnt); end
        tests_run++; if ({o_digit3, o_digit2} !== 14'h3FFF) begin tests_failed++; $display("FAIL inval_digits got %h exp 3fff", {o_digit3, o_digit2}); end
        tests_run++; if (o_stall !== 1'b1) begin tests_failed++; $display("FAIL inval_stall got %b exp 1", o_stall); end
    endtask

    task automatic test_nonhex();
        do_reset(4'hF, 7'h7F);
        drive(4'b1011, 7'h7E, S + LAT);
        tests_run++; if (o_digit2 !== 7'h7E) begin tests_failed++; $display("FAIL nonhex_digit2 got %h exp 7e", o_digit2); end
        tests_run++; if (o_hex2 !== 4'h0) begin tests_failed++; $display("FAIL nonhex_hex2 got %h exp 0", o_hex2); end
        tests_run++; if (o_hex_ok[2] !== 1'b0) begin tests_failed++; $display("FAIL nonhex_ok got %b exp 0", o_hex_ok[2]); end
        tests_run++; if (o_valid !== 4'b0100) begin tests_failed++; $display("FAIL nonhex_valid got %b exp 0100", o_valid); end
    endtask

    task automatic test_stall();
        int k;
        do_reset(4'hF, 7'h7F);
        drive(4'b1110, 7'h19, S + LAT);
        tests_run++; if (o_valid !== 4'b0001) begin tests_failed++; $display("FAIL stall_capture got %b exp 0001", o_valid); end
        k = 0;
        while (o_stall !== 1'b1 && k < 200) begin
            drive(4'hF, 7'h7F, 1);
            k++;
        end
        tests_run++; if (k != MAX_IDLE) begin tests_failed++; $display("FAIL stall_delay got %0d exp %0d", k, MAX_IDLE); end
        drive(4'b1101, 7'h30, S + LAT - 1);
        tests_run++; if (o_stall !== 1'b1) begin tests_failed++; $display("FAIL stall_hold got %b exp 1", o_stall); end
        drive(4'b1101, 7'h30, 1);
        tests_run++; if (o_stall !== 1'b0) begin tests_failed++; $display("FAIL stall_clear got %b exp 0", o_stall); end
        tests_run++; if (o_valid !== 4'b0011) begin tests_failed++; $display("FAIL stall_valid got %b exp 0011", o_valid); end
    endtask

    task automatic test_reset_mid_dwell();
        int edges;
        do_reset(4'hF, 7'h7F);
        drive(4'b1101, 7'h24, S + LAT - 2);
        @(negedge i_clk);
        i_rst = 1'b1;
        model_reset();
        #1;
        tests_run++; if (o_digit1 !== 7'h7F) begin tests_failed++; $display("FAIL mid_rst_digit1 got %h exp 7f", o_digit1); end
        tests_run++; if (o_stall !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_stall got %b exp 0", o_stall); end
        @(posedge i_clk);
        #1;
        tests_run++; if (o_valid !== 4'h0) begin tests_failed++; $display("FAIL mid_rst_valid got %h exp 0", o_valid); end
        i_rst = 1'b0;
        edges = 0;
        while (o_valid[1] !== 1'b1 && edges < 50) begin
            drive(4'b1101, 7'h24, 1);
            edges++;
        end
        tests_run++; if (edges != S + LAT) begin tests_failed++; $display("FAIL mid_rst_latency got %0d exp %0d", edges, S + LAT); end
        tests_run++; if (o_digit1 !== 7'h24) begin tests_failed++; $display("FAIL mid_rst_digit1_after got %h exp 24", o_digit1); end
    endtask

    task automatic test_recapture();
        do_reset(4'hF, 7'h7F);
        frame_cnt = 0;
        drive(4'b1110, 7'h08, S + LAT + 2);
        drive(4'b1101, 7'h03, S + LAT + 2);
        drive(4'b1110, 7'h46, S + LAT + 2);
        drive(4'b1011, 7'h21, S + LAT + 2);
        tests_run++; if (frame_cnt !== 0) begin tests_failed++; $display("FAIL recap_early_frames got %0d exp 0", frame_cnt); end
        tests_run++; if (o_valid !== 4'b0111) begin tests_failed++; $display("FAIL recap_valid got %b exp 0111", o_valid); end
        drive(4'b0111, 7'h06, S + LAT + 2);
        tests_run++; if (frame_cnt !== 1) begin tests_failed++; $display("FAIL recap_frames got %0d exp 1", frame_cnt); end
        tests_run++; if (o_digit0 !== 7'h46) begin tests_failed++; $display("FAIL recap_digit0 got %h exp 46", o_digit0); end
        tests_run++; if ({o_hex3, o_hex0} !== 8'hEC) begin tests_failed++; $display("FAIL recap_hex got %h exp ec", {o_hex3, o_hex0}); end
    endtask

    task automatic test_random();
        logic [3:0] an;
        logic [6:0] seg;
        int r, hold;
        do_reset(4'hF, 7'h7F);
        for (int t = 0; t < 80; t++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       an = 4'(~(4'b0001 << $urandom_range(0, 3)));
            else if (r == 7) an = 4'hF;
            else             an = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) seg = glyph[$urandom_range(0, 15)];
            else                           seg = 7'($urandom_range(0, 127));
            hold = $urandom_range(1, 2 * S + LAT);
            for (int c = 0; c < hold; c++) begin
                drive(an, seg, 1);
                tests_run++;
                if (dut_vec !== exp_vec()) begin
                    tests_failed++;
                    $display("FAIL random_t%0d_c%0d got %h exp %h", t, c, dut_vec, exp_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_capture_latency();
        test_loopback();
        test_glitch();
        test_invalid_anode();
        test_nonhex();
        test_stall();
        test_reset_mid_dwell();
        test_recapture();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
